// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback-port arbiter.
// The optional pending-register mask is enabled by defining WB_ARB_PENDING_EN.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      STARVE = 2'd2
   } arb_state_t;

   localparam int DEF_STARVE_LIMIT = 8;
   localparam int DEF_FIFO_DEPTH   = 2;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } lu_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Shift-style result FIFO (entry 0 is always the head) for long-latency results.
// With WB_ARB_PENDING_EN defined it also keeps a registered mask of buffered destinations.
module wb_arb_fifo
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  lu_entry_t                    din,
   output lu_entry_t                    head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [31:0]                  pending
);

   localparam int CW = $clog2(DEPTH + 1);

   lu_entry_t         mem   [DEPTH];
   lu_entry_t         mem_n [DEPTH];
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_n;
   logic              do_push;
   logic              do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pop shifts first, so a simultaneous push lands behind the surviving entries.
   always_comb begin
      mem_n = mem;
      cnt_n = cnt_q;
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
         cnt_n = cnt_q - 1'b1;
      end
      if (do_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == cnt_n) mem_n[i] = din;
         end
         cnt_n = cnt_n + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         cnt_q <= cnt_n;
         for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      end
   end

   assign head  = mem[0];
   assign count = cnt_q;

`ifdef WB_ARB_PENDING_EN
   logic [31:0] pend_q;
   logic [31:0] pend_n;

   // Built from next-state contents so the mask moves on the same edge as push/pop.
   always_comb begin
      pend_n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < cnt_n && mem_n[i].rd != 5'd0) pend_n[mem_n[i].rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_n;
   end

   assign pending = pend_q;
`else
   assign pending = '0;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: WB stage has fixed priority, long-latency results
// drain from a FIFO in idle WB slots; a starvation FSM asks for a WB bubble (WB_ARB_PENDING_EN optional).
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_regwrite_i,
   input  logic [4:0]  wb_rd_addr_i,
   input  logic [31:0] wb_data_i,
   input  logic        lu_valid_i,
   input  logic [4:0]  lu_rd_addr_i,
   input  logic [31:0] lu_data_i,
   output logic        lu_ready_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        stall_req_o,
   output logic [31:0] pending_mask_o,
   output logic [1:0]  dbg_state
);

   localparam int CW  = $clog2(STARVE_LIMIT + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);

   arb_state_t     state_q, state_n;
   logic [CW-1:0]  cnt_q, cnt_n;
   logic           run_q;
   logic           wb_eff, push, pop;
   logic           full, empty;
   logic [FCW-1:0] count;
   lu_entry_t      head, din;

   // Handshake: a long-latency result transfers on a rising edge where lu_valid_i and
   // lu_ready_o are both high; lu_ready_o depends on registered state only.
   assign lu_ready_o = run_q && !full;
   assign push       = lu_valid_i && lu_ready_o;
   assign wb_eff     = wb_regwrite_i && (wb_rd_addr_i != 5'd0);
   assign pop        = !wb_eff && !empty;
   assign din        = '{rd: lu_rd_addr_i, data: lu_data_i};

   wb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .din     (din),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .pending (pending_mask_o)
   );

   // rst_n gates the write port so no WB write leaks out while in reset.
   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (rst_n) begin
         if (wb_eff) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_rd_addr_i;
            rf_wdata_o = wb_data_i;
         end else if (!empty) begin
            rf_we_o    = (head.rd != 5'd0);
            rf_waddr_o = head.rd;
            rf_wdata_o = head.data;
         end
      end
   end

   always_comb begin
      cnt_n   = cnt_q;
      state_n = state_q;
      if (pop || empty)                  cnt_n = '0;
      else if (cnt_q != CW'(STARVE_LIMIT)) cnt_n = cnt_q + 1'b1;
      case (state_q)
         IDLE: if (push) state_n = PEND;
         PEND: begin
            if (pop && !push && count == FCW'(1))        state_n = IDLE;
            else if (!pop && cnt_n == CW'(STARVE_LIMIT)) state_n = STARVE;
         end
         STARVE: begin
            if (pop) state_n = (!push && count == FCW'(1)) ? IDLE : PEND;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         run_q   <= 1'b1;
      end
   end

   assign stall_req_o = (state_q == STARVE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expected values are hand-computed per scenario.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_regwrite_i = 1'b0;
   logic [4:0]  wb_rd_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        lu_valid_i = 1'b0;
   logic [4:0]  lu_rd_addr_i = '0;
   logic [31:0] lu_data_i = '0;
   logic        lu_ready_o, rf_we_o, stall_req_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o, pending_mask_o;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .wb_regwrite_i(wb_regwrite_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
      .lu_valid_i(lu_valid_i), .lu_rd_addr_i(lu_rd_addr_i), .lu_data_i(lu_data_i),
      .lu_ready_o(lu_ready_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
      .rf_wdata_o(rf_wdata_o), .stall_req_o(stall_req_o),
      .pending_mask_o(pending_mask_o), .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      wb_regwrite_i = wv; wb_rd_addr_i = wrd; wb_data_i = wd;
      lu_valid_i = lv; lu_rd_addr_i = lrd; lu_data_i = ld;
      #1;
   endtask

   task automatic test_reset();
      logic [73:0] obs;
      rst_n = 1'b0;
      drive(1'b1, 5'd4, 32'h5, 1'b1, 5'd6, 32'h7);
      obs = {lu_ready_o, stall_req_o, rf_we_o, rf_waddr_o, rf_wdata_o, pending_mask_o, dbg_state};
      n_vec++; if (obs !== '0) begin n_err++; $display("FAIL reset_outs: got %h exp 0", obs); end
      tick();
      obs = {lu_ready_o, stall_req_o, rf_we_o, rf_waddr_o, rf_wdata_o, pending_mask_o, dbg_state};
      n_vec++; if (obs !== '0) begin n_err++; $display("FAIL reset_held: got %h exp 0", obs); end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rst_n = 1'b1;
      #1;
      n_vec++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL ready_pre_edge: got %b exp 0", lu_ready_o); end
      tick();
      n_vec++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL ready_first_edge: got %b exp 1", lu_ready_o); end
   endtask

   task automatic test_single_push();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
      n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL s1_no_bypass: got %b exp 0", rf_we_o); end
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_vec++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'h1234}) begin
         n_err++; $display("FAIL s1_write: got %b/%0d/%h exp 1/5/1234", rf_we_o, rf_waddr_o, rf_wdata_o); end
      n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL s1_pend: got %0d exp 1", dbg_state); end
      tick();
      n_vec++; if ({dbg_state, rf_we_o} !== {2'd0, 1'b0}) begin
         n_err++; $display("FAIL s1_idle: got state %0d we %b exp 0 0", dbg_state, rf_we_o); end
   endtask

   task automatic test_wb_priority();
      drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
      tick();
      drive(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 32'h0);
      n_vec++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'hAAAA}) begin
         n_err++; $display("FAIL s2_wb_wins: got %b/%0d/%h exp 1/3/aaaa", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_vec++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'hBBBB}) begin
         n_err++; $display("FAIL s2_fifo_after: got %b/%0d/%h exp 1/7/bbbb", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL s2_idle: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_starve();
      logic [31:0] exp_mask;
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'h1);
      tick();
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'h2);
      tick();
`ifdef WB_ARB_PENDING_EN
      exp_mask = 32'h0000_0C00;
`else
      exp_mask = 32'h0;
`endif
      n_vec++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL s3_full: got %b exp 0", lu_ready_o); end
      n_vec++; if (pending_mask_o !== exp_mask) begin
         n_err++; $display("FAIL s3_mask: got %h exp %h", pending_mask_o, exp_mask); end
      drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0);
      for (int i = 2; i <= 7; i++) tick();
      n_vec++; if (stall_req_o !== 1'b0) begin n_err++; $display("FAIL s3_no_stall_7: got %b exp 0", stall_req_o); end
      tick();
      n_vec++; if ({stall_req_o, dbg_state} !== {1'b1, 2'd2}) begin
         n_err++; $display("FAIL s3_starve: got %b/%0d exp 1/2", stall_req_o, dbg_state); end
      drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
      n_vec++; if ({rf_waddr_o, rf_wdata_o} !== {5'd2, 32'h22}) begin
         n_err++; $display("FAIL s3_wb_in_starve: got %0d/%h exp 2/22", rf_waddr_o, rf_wdata_o); end
      tick();
      n_vec++; if (stall_req_o !== 1'b1) begin n_err++; $display("FAIL s3_starve_held: got %b exp 1", stall_req_o); end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_vec++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd10, 32'h1}) begin
         n_err++; $display("FAIL s3_pop1: got %b/%0d/%h exp 1/10/1", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      n_vec++; if ({stall_req_o, lu_ready_o, dbg_state} !== {1'b0, 1'b1, 2'd1}) begin
         n_err++; $display("FAIL s3_release: got %b/%b/%0d exp 0/1/1", stall_req_o, lu_ready_o, dbg_state); end
      n_vec++; if ({rf_waddr_o, rf_wdata_o} !== {5'd11, 32'h2}) begin
         n_err++; $display("FAIL s3_pop2: got %0d/%h exp 11/2", rf_waddr_o, rf_wdata_o); end
      tick();
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL s3_idle: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_x0();
      logic [31:0] exp_mask;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h42);
      tick();
      drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1);
      n_vec++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h42}) begin
         n_err++; $display("FAIL s4_x0_ignored: got %b/%0d/%h exp 1/9/42", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      exp_mask = 32'h0;
      n_vec++; if (pending_mask_o !== exp_mask) begin
         n_err++; $display("FAIL s4_mask_x0: got %h exp %h", pending_mask_o, exp_mask); end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL s4_x0_head: got %b exp 0", rf_we_o); end
      tick();
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL s4_idle: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_full_pop_push();
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'h12);
      tick();
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd13, 32'h13);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h14);
      n_vec++; if ({lu_ready_o, rf_waddr_o} !== {1'b0, 5'd12}) begin
         n_err++; $display("FAIL s5_full_pop: got %b/%0d exp 0/12", lu_ready_o, rf_waddr_o); end
      tick();
      n_vec++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL s5_ready_back: got %b exp 1", lu_ready_o); end
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd14, 32'h14);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_vec++; if ({rf_waddr_o, rf_wdata_o} !== {5'd13, 32'h13}) begin
         n_err++; $display("FAIL s5_second: got %0d/%h exp 13/13", rf_waddr_o, rf_wdata_o); end
      tick();
      n_vec++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd14, 32'h14}) begin
         n_err++; $display("FAIL s5_late_push: got %b/%0d/%h exp 1/14/14", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
      n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL s5_idle: got %0d exp 0", dbg_state); end
   endtask

   task automatic test_reset_mid();
      logic [73:0] obs;
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'h20);
      tick();
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd21, 32'h21);
      tick();
      drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0);
      for (int i = 2; i <= 8; i++) tick();
      n_vec++; if (stall_req_o !== 1'b1) begin n_err++; $display("FAIL s6_starve: got %b exp 1", stall_req_o); end
      rst_n = 1'b0;
      #1;
      obs = {lu_ready_o, stall_req_o, rf_we_o, rf_waddr_o, rf_wdata_o, pending_mask_o, dbg_state};
      n_vec++; if (obs !== '0) begin n_err++; $display("FAIL s6_async_clear: got %h exp 0", obs); end
      tick();
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rst_n = 1'b1;
      #1;
      n_vec++; if ({rf_we_o, lu_ready_o} !== 2'b00) begin
         n_err++; $display("FAIL s6_post_release: got we %b rdy %b exp 0 0", rf_we_o, lu_ready_o); end
      tick();
      obs = {lu_ready_o, stall_req_o, rf_we_o, rf_waddr_o, rf_wdata_o, pending_mask_o, dbg_state};
      n_vec++; if (obs !== {1'b1, 73'h0}) begin n_err++; $display("FAIL s6_no_stale: got %h exp ready only", obs); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_wb_priority();
      test_starve();
      test_x0();
      test_full_pop_push();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
